hack_memory: RTL and testbench

Data-memory responder for the Hack CPU: it serves the CPU's memory port (`addressM`, `writeM`, `outM` in; `inM` out) with a 16K-word RAM, an 8K-word screen buffer and a memory-mapped keyboard register. Keyboard codes arrive on a valid/ready handshake and are buffered. A second, registered read port lets a display scanner read the screen buffer without disturbing the CPU. Sits beside `cpu` at the top level, with the same `clk` and `reset`.

---
 rtl/hack_mem_pkg.sv | 25 ++
 rtl/hack_memory_kbd_fifo.sv | 97 +++++++++
 rtl/hack_memory.sv | 78 +++++++
 tb/tb_hack_memory.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared constants, region encoding and address decode for the Hack data memory.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE    = 15'h0000;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  localparam int unsigned RAM_WORDS    = 16384;
  localparam int unsigned SCREEN_WORDS = 8192;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_t;

  function automatic region_t decode_region(input logic [14:0] addr);
    if (addr < SCREEN_BASE)   return REG_RAM;
    else if (addr < KBD_ADDR) return REG_SCREEN;
    else if (addr == KBD_ADDR) return REG_KBD;
    else                      return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_memory_kbd_fifo.sv
// Keyboard code buffer: DEPTH-entry FIFO when HACK_MEM_KBD_FIFO_EN is defined,
// otherwise a single holding register (equivalent to a depth-1 FIFO).
module kbd_fifo
  import hack_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_valid,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic        ready,
  output logic [15:0] head
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kbd_fifo: DEPTH must be a power of two and at least 2");
  end

`ifdef HACK_MEM_KBD_FIFO_EN

  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  // Head and ready are forced idle while reset is held so nothing leaks out.
  always_comb begin
    empty   = (count == '0);
    full    = (count == (AW + 1)'(DEPTH));
    ready   = !full && !reset;
    do_push = push_valid && ready && (push_data != '0);
    do_pop  = pop && !empty && !reset;
    head    = (empty || reset) ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`else

  logic [15:0] hold;
  logic        full;
  logic        do_push;

  // A push always wins over a pop when empty; when full, ready is low so only the pop lands.
  always_comb begin
    ready   = !full && !reset;
    do_push = push_valid && ready && (push_data != '0);
    head    = (full && !reset) ? hold : '0;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      hold <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
    end else if (do_push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/hack_memory.sv
// Hack CPU data memory: RAM, screen buffer with a registered scan port, and the
// keyboard register/FIFO (FIFO selected by HACK_MEM_KBD_FIFO_EN).
module hack_memory
  import hack_mem_pkg::*;
#(
  parameter int unsigned KBD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] inM,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  output logic        kbd_ready,
  input  logic [12:0] scan_addr,
  output logic [15:0] scan_data
);

  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];

  logic [14:0] addr;
  logic        unused_addr_msb;
  region_t     region;
  logic        kbd_pop;
  logic [15:0] kbd_head;

  assign addr            = addressM[14:0];
  assign unused_addr_msb = addressM[15];
  assign region          = decode_region(addr);
  assign kbd_pop         = writeM && (region == REG_KBD);

  always_ff @(posedge clk) begin
    if (writeM && region == REG_RAM) begin
      ram[addr[13:0]] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (writeM && region == REG_SCREEN) begin
      screen[addr[12:0]] <= outM;
    end
  end

  // Scan read samples the array before this edge's CPU write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_data <= '0;
    end else begin
      scan_data <= screen[scan_addr];
    end
  end

  always_comb begin
    inM = '0;
    case (region)
      REG_RAM:    inM = ram[addr[13:0]];
      REG_SCREEN: inM = screen[addr[12:0]];
      REG_KBD:    inM = kbd_head;
      default:    inM = '0;
    endcase
  end

  kbd_fifo #(
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (kbd_valid),
    .push_data  (kbd_code),
    .pop        (kbd_pop),
    .ready      (kbd_ready),
    .head       (kbd_head)
  );

endmodule

// File: tb/tb_hack_memory.sv
// Directed bench for hack_memory with an expected-value scoreboard and a keyboard queue model.
module tb_hack_memory;

`ifdef HACK_MEM_KBD_FIFO_EN
  localparam int KD = 4;
`else
  localparam int KD = 1;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_ready;
  logic [12:0] scan_addr;
  logic [15:0] scan_data;

  hack_memory #(
    .KBD_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .writeM    (writeM),
    .outM      (outM),
    .inM       (inM),
    .kbd_valid (kbd_valid),
    .kbd_code  (kbd_code),
    .kbd_ready (kbd_ready),
    .scan_addr (scan_addr),
    .scan_data (scan_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] kq[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic expect_val(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [15:0] model_head();
    return (kq.size() > 0 && !reset) ? kq[0] : 16'h0000;
  endfunction

  function automatic logic [15:0] model_ready();
    return {15'd0, (!reset && kq.size() < KD)};
  endfunction

  // Advance one clock, applying the keyboard queue model with pre-edge state.
  task automatic tick();
    logic acc;
    logic pop;
    acc = kbd_valid && !reset && (kq.size() < KD) && (kbd_code != 16'h0000);
    pop = !reset && writeM && (addressM[14:0] == 15'h6000) && (kq.size() > 0);
    if (reset) begin
      kq.delete();
    end else begin
      if (pop) void'(kq.pop_front());
      if (acc) kq.push_back(kbd_code);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addressM = a;
    writeM   = 1'b0;
    expect_val(tag, exp);
    #1;
    compare(inM);
    tick();
  endtask

  task automatic sample_kbd(input string tag);
    addressM = 16'h6000;
    expect_val({tag, "_kbd"}, model_head());
    expect_val({tag, "_ready"}, model_ready());
    #1;
    compare(inM);
    compare({15'd0, kbd_ready});
  endtask

  task automatic sample_scan(input string tag, input logic [15:0] exp);
    expect_val(tag, exp);
    compare(scan_data);
  endtask

  initial begin
    reset     = 1'b1;
    writeM    = 1'b0;
    addressM  = 16'h0000;
    outM      = 16'h0000;
    kbd_valid = 1'b0;
    kbd_code  = 16'h0000;
    scan_addr = 13'h0000;
    tick();
    tick();
    sample_kbd("in_reset");
    sample_scan("rst_scan", 16'h0000);
    reset = 1'b0;
    tick();
    sample_kbd("post_reset");
    tick();

    // RAM
    cpu_write(16'h0006, 16'h5A5A);
    cpu_write(16'h0005, 16'h1234);
    read_chk("ram5", 16'h0005, 16'h1234);
    read_chk("ram6_kept", 16'h0006, 16'h5A5A);
    read_chk("ram5_msb_ignored", 16'h8005, 16'h1234);
    cpu_write(16'h3FFF, 16'hC0DE);
    read_chk("ram_top", 16'h3FFF, 16'hC0DE);

    // Screen and scan port
    cpu_write(16'h4010, 16'h0F0F);
    scan_addr = 13'h0010;
    addressM  = 16'h4010;
    outM      = 16'hFFFF;
    writeM    = 1'b1;
    tick();
    writeM = 1'b0;
    sample_scan("scan_rbw_old", 16'h0F0F);
    tick();
    sample_scan("scan_new", 16'hFFFF);
    read_chk("scr_cpu", 16'h4010, 16'hFFFF);
    cpu_write(16'h5FFF, 16'hBEEF);
    scan_addr = 13'h1FFF;
    tick();
    sample_scan("scan_last", 16'hBEEF);
    read_chk("scr_last", 16'h5FFF, 16'hBEEF);
    read_chk("scr_first_is_ram_edge", 16'h3FFF, 16'hC0DE);

    // Unmapped
    read_chk("unmap_6001", 16'h6001, 16'h0000);
    read_chk("unmap_7fff", 16'h7FFF, 16'h0000);
    cpu_write(16'h3000, 16'h1111);
    cpu_write(16'h7000, 16'hABCD);
    read_chk("ram3000_kept", 16'h3000, 16'h1111);
    read_chk("unmap_7000", 16'h7000, 16'h0000);

    // Keyboard: zero code is dropped
    kbd_valid = 1'b1;
    kbd_code  = 16'h0000;
    tick();
    kbd_valid = 1'b0;
    sample_kbd("zero_drop");
    tick();

    // Fill to full
    for (int i = 0; i < KD; i++) begin
      kbd_valid = 1'b1;
      kbd_code  = 16'(16'h0041 + i);
      sample_kbd("fill");
      tick();
    end
    kbd_valid = 1'b0;
    sample_kbd("full");
    tick();
    cpu_write(16'h6000, 16'hDEAD);
    sample_kbd("pop1");
    tick();
    for (int i = 0; i < KD; i++) begin
      cpu_write(16'h6000, 16'hDEAD);
      sample_kbd("drain");
      tick();
    end

    // Full with simultaneous pop: push held off one cycle
    for (int i = 0; i < KD; i++) begin
      kbd_valid = 1'b1;
      kbd_code  = 16'(16'h0041 + i);
      tick();
    end
    kbd_code = 16'(16'h0041 + KD);
    addressM = 16'h6000;
    writeM   = 1'b1;
    sample_kbd("full_pop");
    tick();
    writeM = 1'b0;
    sample_kbd("after_full_pop");
    tick();
    kbd_valid = 1'b0;
    for (int i = 0; i < KD; i++) begin
      sample_kbd("order");
      cpu_write(16'h6000, 16'h0000);
    end
    sample_kbd("order_empty");
    tick();

    // Empty: push and pop together -> only push
    kbd_valid = 1'b1;
    kbd_code  = 16'h0060;
    addressM  = 16'h6000;
    writeM    = 1'b1;
    tick();
    writeM    = 1'b0;
    kbd_valid = 1'b0;
    sample_kbd("empty_pushpop");
    tick();
    // One entry: push and pop together
    kbd_valid = 1'b1;
    kbd_code  = 16'h0061;
    addressM  = 16'h6000;
    writeM    = 1'b1;
    tick();
    writeM    = 1'b0;
    kbd_valid = 1'b0;
    sample_kbd("mid_pushpop");
    tick();
    cpu_write(16'h6000, 16'h0000);
    cpu_write(16'h6000, 16'h0000);
    sample_kbd("cleared");
    tick();

    // Reset mid-operation
    kbd_valid = 1'b1;
    kbd_code  = 16'h0041;
    scan_addr = 13'h0010;
    tick();
    kbd_valid = 1'b0;
    tick();
    sample_scan("pre_reset_scan", 16'hFFFF);
    sample_kbd("pre_reset");
    kbd_valid = 1'b1;
    kbd_code  = 16'h0050;
    reset     = 1'b1;
    sample_kbd("reset_cycle");
    tick();
    sample_scan("reset_scan", 16'h0000);
    sample_kbd("reset_after_edge");
    reset     = 1'b0;
    kbd_valid = 1'b0;
    tick();
    sample_kbd("post_reset2");
    tick();
    read_chk("ram5_survives_reset", 16'h0005, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
